// File: rtl/shift_sequencer_pkg.sv
// Shared ALU definitions used by the multi-bit shift sequencer:
// state encoding, shift directions and shift-unit function codes.
package shift_sequencer_pkg;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned AMT_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic DIR_SHR = 1'b0;
    localparam logic DIR_SHL = 1'b1;

    localparam logic [1:0] FUNC_SHR = 2'b00;
    localparam logic [1:0] FUNC_SHL = 2'b01;

    // Map a shift direction onto the shift unit's function code.
    function automatic logic [1:0] su_func_of(input logic dir);
        return (dir == DIR_SHL) ? FUNC_SHL : FUNC_SHR;
    endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller: drives the ALU's single-bit shift unit once per
// cycle, feeding each registered result back, and returns the final value.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned Width    = WIDTH,
    parameter int unsigned AmtWidth = AMT_WIDTH
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CMD_VALID,
    output logic                CMD_READY,
    input  logic [Width-1:0]    CMD_OPERAND,
    input  logic                CMD_DIR,
    input  logic [AmtWidth-1:0] CMD_AMT,
    output logic                RES_VALID,
    input  logic                RES_READY,
    output logic [Width-1:0]    RESULT,
    output logic                RES_ERR,
    output logic [Width-1:0]    SU_A,
    output logic [Width-1:0]    SU_B,
    output logic [1:0]          SU_FUNC,
    output logic                SU_EN,
    input  logic [Width-1:0]    SU_OUT,
    input  logic                SU_FLAG
);

    localparam logic [AmtWidth-1:0] AMT_LIMIT = AmtWidth'(Width);
    localparam logic [AmtWidth-1:0] AMT_ONE   = AmtWidth'(1);

    state_t                state_q, state_d;
    logic [AmtWidth-1:0]   cnt_q, cnt_d;
    logic                  first_q, first_d;
    logic [Width-1:0]      op_q, op_d;
    logic                  dir_q, dir_d;
    logic [Width-1:0]      result_q, result_d;
    logic                  err_q, err_d;
    logic                  cmd_ready_q;
    logic                  res_valid_q;
    logic                  su_en_q;
    logic [1:0]            su_func_q;
    logic [Width-1:0]      su_a_c;
    logic                  cmd_accept_c;

    assign cmd_accept_c = CMD_VALID && cmd_ready_q;

    // Next-state, datapath next values and the shift-unit operand mux.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        op_d     = op_q;
        dir_d    = dir_q;
        result_d = result_q;
        err_d    = err_q;
        su_a_c   = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_accept_c) begin
                    op_d  = CMD_OPERAND;
                    dir_d = CMD_DIR;
                    err_d = 1'b0;
                    if (CMD_AMT == '0) begin
                        result_d = CMD_OPERAND;
                        state_d  = ST_DONE;
                    end else if (CMD_AMT >= AMT_LIMIT) begin
                        result_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d   = CMD_AMT;
                        first_d = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                su_a_c  = first_q ? op_q : SU_OUT;
                first_d = 1'b0;
                // A missing flag on any step after the first aborts the command.
                if (!first_q && !SU_FLAG) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - AMT_ONE;
                    if (cnt_q == AMT_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!SU_FLAG) begin
                    result_d = '0;
                    err_d    = 1'b1;
                end else begin
                    result_d = SU_OUT;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (RES_READY && res_valid_q) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs, decoded from the upcoming state.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            op_q        <= '0;
            dir_q       <= DIR_SHR;
            result_q    <= '0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            su_en_q     <= 1'b0;
            su_func_q   <= FUNC_SHR;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            op_q        <= op_d;
            dir_q       <= dir_d;
            result_q    <= result_d;
            err_q       <= err_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            res_valid_q <= (state_d == ST_DONE);
            su_en_q     <= (state_d == ST_RUN);
            su_func_q   <= su_func_of(dir_d);
        end
    end

    assign CMD_READY = cmd_ready_q;
    assign RES_VALID = res_valid_q;
    assign RESULT    = result_q;
    assign RES_ERR   = err_q;
    assign SU_A      = su_a_c;
    assign SU_B      = '0;
    assign SU_FUNC   = su_func_q;
    assign SU_EN     = su_en_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural single-bit shift unit
// sharing RST, and a scoreboard of expected results.
module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    logic        CLK;
    logic        RST;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [15:0] CMD_OPERAND;
    logic        CMD_DIR;
    logic [4:0]  CMD_AMT;
    logic        RES_VALID;
    logic        RES_READY;
    logic [15:0] RESULT;
    logic        RES_ERR;
    logic [15:0] SU_A;
    logic [15:0] SU_B;
    logic [1:0]  SU_FUNC;
    logic        SU_EN;
    logic [15:0] SU_OUT;
    logic        SU_FLAG;

    typedef struct packed {
        logic [15:0] res;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic [7:0] su_step;
    logic [7:0] fault_step;

    shift_sequencer #(.Width(16), .AmtWidth(5)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OPERAND(CMD_OPERAND), .CMD_DIR(CMD_DIR), .CMD_AMT(CMD_AMT),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RESULT(RESULT), .RES_ERR(RES_ERR),
        .SU_A(SU_A), .SU_B(SU_B), .SU_FUNC(SU_FUNC), .SU_EN(SU_EN),
        .SU_OUT(SU_OUT), .SU_FLAG(SU_FLAG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Shift unit model; fault_step suppresses the flag of that step's result.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            SU_OUT  <= '0;
            SU_FLAG <= 1'b0;
            su_step <= '0;
        end else if (SU_EN) begin
            SU_OUT  <= (SU_FUNC == FUNC_SHL) ? (SU_A << 1) : (SU_A >> 1);
            SU_FLAG <= !((fault_step != 8'd0) && (su_step + 8'd1 == fault_step));
            su_step <= su_step + 8'd1;
        end else begin
            SU_FLAG <= 1'b0;
            su_step <= '0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model(input logic [15:0] op, input logic dir, input logic [4:0] amt);
        if (amt >= 5'd16) return 16'h0000;
        return dir ? (op << amt) : (op >> amt);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag, input logic [15:0] op, input logic dir,
                         input logic [4:0] amt, input logic fault);
        exp_t e;
        int   n = 0;
        @(negedge CLK);
        while (!CMD_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_ready"}, 32'(CMD_READY), 32'd1);
        CMD_VALID   = 1'b1;
        CMD_OPERAND = op;
        CMD_DIR     = dir;
        CMD_AMT     = amt;
        @(posedge CLK);
        e.res = fault ? 16'h0000 : model(op, dir, amt);
        e.err = fault;
        sb.push_back(e);
        #1 CMD_VALID = 1'b0;
    endtask

    // Waits for RES_VALID (bounded) and checks latency, SU_EN activity and payload.
    task automatic collect(input string tag, input int exp_lat, input int exp_en, input logic [1:0] exp_func);
        exp_t e;
        int   lat  = 0;
        int   en   = 0;
        int   fbad = 0;
        while (lat < 200) begin
            @(negedge CLK);
            lat++;
            if (SU_EN) begin
                en++;
                if (SU_FUNC !== exp_func) fbad++;
            end
            if (RES_VALID) break;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_su_en_cycles"}, 32'(en), 32'(exp_en));
        chk({tag, "_su_func_bad"}, 32'(fbad), 32'd0);
        chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_result"}, 32'(RESULT), 32'(e.res));
            chk({tag, "_err"}, 32'(RES_ERR), 32'(e.err));
        end
    endtask

    task automatic consume();
        RES_READY = 1'b1;
        @(posedge CLK);
        #1 RES_READY = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(CMD_READY), 32'd0);
        chk({tag, "_res_valid"}, 32'(RES_VALID), 32'd0);
        chk({tag, "_res_err"}, 32'(RES_ERR), 32'd0);
        chk({tag, "_su_en"}, 32'(SU_EN), 32'd0);
        chk({tag, "_result"}, 32'(RESULT), 32'd0);
        chk({tag, "_su_a"}, 32'(SU_A), 32'd0);
        chk({tag, "_su_b"}, 32'(SU_B), 32'd0);
        chk({tag, "_su_func"}, 32'(SU_FUNC), 32'd0);
        chk({tag, "_state"}, 32'(dut.state_q), 32'(ST_IDLE));
    endtask

    initial begin
        RST         = 1'b0;
        CMD_VALID   = 1'b0;
        CMD_OPERAND = '0;
        CMD_DIR     = 1'b0;
        CMD_AMT     = '0;
        RES_READY   = 1'b0;
        fault_step  = 8'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("por");
        RST = 1'b1;

        issue("shl4", 16'h0001, DIR_SHL, 5'd4, 1'b0);
        collect("shl4", 6, 4, FUNC_SHL);
        consume();

        issue("shr15", 16'h8000, DIR_SHR, 5'd15, 1'b0);
        collect("shr15", 17, 15, FUNC_SHR);
        consume();

        issue("shr3", 16'hF0F0, DIR_SHR, 5'd3, 1'b0);
        collect("shr3", 5, 3, FUNC_SHR);
        consume();

        issue("amt0", 16'hABCD, DIR_SHL, 5'd0, 1'b0);
        collect("amt0", 1, 0, FUNC_SHL);
        consume();

        issue("amt16", 16'hABCD, DIR_SHL, 5'd16, 1'b0);
        collect("amt16", 1, 0, FUNC_SHL);
        consume();

        issue("amt31", 16'hABCD, DIR_SHR, 5'd31, 1'b0);
        collect("amt31", 1, 0, FUNC_SHR);
        consume();

        // Result backpressure with a new command waiting.
        issue("bp1", 16'h00FF, DIR_SHL, 5'd2, 1'b0);
        collect("bp1", 4, 2, FUNC_SHL);
        CMD_VALID   = 1'b1;
        CMD_OPERAND = 16'h1234;
        CMD_DIR     = DIR_SHR;
        CMD_AMT     = 5'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp_hold_result", 32'(RESULT), 32'h03FC);
            chk("bp_hold_valid", 32'(RES_VALID), 32'd1);
            chk("bp_hold_cmd_ready", 32'(CMD_READY), 32'd0);
        end
        RES_READY = 1'b1;
        @(posedge CLK);
        #1 RES_READY = 1'b0;
        @(negedge CLK);
        chk("bp_after_cmd_ready", 32'(CMD_READY), 32'd1);
        chk("bp_after_res_valid", 32'(RES_VALID), 32'd0);
        sb.push_back('{res: model(16'h1234, DIR_SHR, 5'd0), err: 1'b0});
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        collect("bp2", 1, 0, FUNC_SHR);
        consume();

        // Reset in the middle of an 8-step shift.
        issue("rst_mid", 16'h0101, DIR_SHL, 5'd8, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("rst_mid");
        sb.delete();
        RST = 1'b1;
        issue("post_rst", 16'h0003, DIR_SHL, 5'd2, 1'b0);
        collect("post_rst", 4, 2, FUNC_SHL);
        consume();

        // Missing flag on step 3 of a 5-step shift.
        fault_step = 8'd3;
        issue("fault", 16'h0F00, DIR_SHR, 5'd5, 1'b1);
        collect("fault", 5, 4, FUNC_SHR);
        consume();
        fault_step = 8'd0;

        issue("recover", 16'h0F00, DIR_SHR, 5'd5, 1'b0);
        collect("recover", 7, 5, FUNC_SHR);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-bit shift controller for the ALU's single-bit shift unit. It accepts a shift command (operand, direction, amount) over a valid/ready handshake. It then issues one single-bit shift per cycle to the shift unit, feeding each registered result back as the next operand, and returns the final value over a second valid/ready handshake. It sits between the ALU command decoder and the shift unit instance in the ALU top level.

## Interface
- Width, 16, operand/result width; also the shift unit's width.
- AmtWidth, 5, shift amount width; must be at least $clog2(Width)+1.

- CLK  in  1  single clock; all state updates on its rising edge.
- RST  in  1  reset, synchronous, active-low.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  command accepted when VALID && READY at a rising edge.
- CMD_OPERAND  in  Width  value to shift.
- CMD_DIR  in  1  0 = logical right, 1 = logical left.
- CMD_AMT  in  AmtWidth  number of bit positions.
- RES_VALID  out  1  result available.
- RES_READY  in  1  result consumed when VALID && READY at a rising edge.
- RESULT  out  Width  shifted value.
- RES_ERR  out  1  shift unit failed to flag a step; qualified by RES_VALID.
- SU_A  out  Width  shift unit operand A.
- SU_B  out  Width  shift unit operand B; always 0.
- SU_FUNC  out  2  shift unit function; {1'b0, dir}, giving 00 = A>>1 and 01 = A<<1.
- SU_EN  out  1  shift unit enable.
- SU_OUT  in  Width  shift unit registered result.
- SU_FLAG  in  1  shift unit registered valid flag.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **Reset** (RST low at an edge): state goes to IDLE. CMD_READY, RES_VALID, RES_ERR, SU_EN and the step counter are 0. RESULT and SU_A are 0x0. SU_FUNC is 00.
- **IDLE:**
  - CMD_READY = 1.
  - On accept, latch operand and direction.
  - CMD_AMT == 0: RESULT = operand, go to DONE.
  - CMD_AMT >= Width: RESULT = 0, go to DONE.
  - Otherwise: counter = CMD_AMT, go to RUN.
- **RUN:**
  - SU_EN = 1.
  - SU_A = latched operand on the first step, SU_OUT on every later step (combinational feed-through).
  - Counter decrements each cycle. When the counter reaches 1 in this cycle, the next state is DRAIN.
- **DRAIN:**
  - SU_EN = 0.
  - RESULT captured from SU_OUT, then go to DONE.
- **DONE:**
  - RES_VALID = 1.
  - RESULT and RES_ERR are held stable until RES_READY.
  - On consumption, return to IDLE with RES_VALID = 0.
- **Flag check:** in every RUN cycle except the first, and in DRAIN, SU_FLAG must be 1.
  - If it is 0, abort to DONE with RESULT = 0 and RES_ERR = 1.
  - Remaining steps are not issued.
- **Command backpressure:** CMD_READY is 0 outside IDLE, so at most one command is in flight. CMD_VALID in other states is ignored.
- **Width rules:** shifts are logical with zero fill. The counter is AmtWidth bits and never wraps, because it only loads values below Width.

## Timing
- Accept at edge t with amount N, 1 <= N < Width:
  - SU_EN high for cycles t+1 .. t+N, exactly N cycles.
  - SU_OUT of step k is valid in cycle t+1+k.
  - DRAIN occurs in cycle t+N+1.
  - RES_VALID rises in cycle t+N+2.
- Shortcut cases (N = 0 or N >= Width): RES_VALID in cycle t+1; SU_EN never asserted.
- Result consumed at edge u: CMD_READY = 1 in cycle u+1. There is no same-cycle turnaround.
- Reset mid-operation: takes effect at the next edge. The shift unit must share RST so no stale SU_FLAG leaks into the next command.

## Structure
- Shared ALU package holds:
  - state encoding localparams (IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3);
  - direction constants (SHR = 1'b0, SHL = 1'b1);
  - shift function codes 2'b00 and 2'b01.
- The block has no sub-module. SHIFT_UNIT is instantiated beside it in the ALU top level and connected through the SU_* ports.
- The testbench instantiates both, with RST shared between them.

## Test plan
- Operand 0x0001, DIR = 1, AMT = 4 -> RESULT 0x0010, RES_ERR 0. RES_VALID 6 cycles after accept. SU_EN high exactly 4 cycles; SU_FUNC = 01 throughout.
- Operand 0x8000, DIR = 0, AMT = 15 -> RESULT 0x0001 with RES_VALID 17 cycles after accept. Operand 0xF0F0, DIR = 0, AMT = 3 -> RESULT 0x1E1E.
- Operand 0xABCD with AMT = 0 -> RESULT 0xABCD. AMT = 16 and AMT = 31 -> RESULT 0x0000. All three have RES_VALID 1 cycle after accept and SU_EN never high.
- RES_READY held low 5 cycles in DONE, with CMD_VALID high and a new operand presented:
  - RESULT and RES_VALID stay stable and CMD_READY stays 0;
  - after RES_READY the pending command is accepted in the cycle after consumption.
- RST driven low after 2 of 8 steps -> next cycle all outputs at reset values, state IDLE. A fresh command (0x0003, DIR = 1, AMT = 2) then returns 0x000C.
- SU_FLAG forced 0 during step 3 of a 5-step shift -> RES_VALID with RES_ERR = 1 and RESULT 0x0000. SU_EN deasserted from the cycle after the fault.
